uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised successor to the team's fixed-format UART receiver. Adds runtime-programmable baud divisor, 5–8 data bits, optional even/odd parity and 1 or 2 stop bits. Adds oversampled majority-vote sampling with false-start rejection, and an output FIFO with valid/ready handshake and overrun reporting. Sits between the board-level RX pin and any byte-stream consumer in the clk_i domain.

Parameters:
OVERSAMPLE, 16, oversample ticks per bit; even, 8..32
DIV_W, 16, width of baud divisor input
FIFO_DEPTH, 8, output FIFO entries; power of 2, >=2

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; one clock; reset is synchronous and active-high
uart_rx_i  in  1  asynchronous serial input, idle high
div_i  in  DIV_W  oversample tick period minus 1, in clk_i cycles
data_bits_i  in  2  0:5, 1:6, 2:7, 3:8 data bits
parity_i  in  2  0:none, 1:even, 2:odd, 3:none
stop2_i  in  1  1 = two stop bits checked
rx_data_o  out  8  FIFO head data, right-justified, unused MSBs 0
rx_perr_o  out  1  FIFO head parity error flag
rx_ferr_o  out  1  FIFO head framing error flag
rx_valid_o  out  1  FIFO not empty
rx_ready_i  in  1  consumer accepts head
level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overrun_o  out  1  one-cycle pulse: completed frame dropped, FIFO full
busy_o  out  1  receiver not IDLE

Behaviour:
- Reset values: sync flops 1; FSM IDLE; all outputs 0; FIFO empty. Reset mid-frame aborts the frame with no push.
- Input: 2-flop synchroniser plus one history flop. Start = synced 0 while previous 1.
- Tick generator: counter 0..div_i, tick when count==div_i; period div_i+1 clocks. div_i=0 gives a tick every clock. Counter cleared on start detection.
- Config (div_i, data_bits_i, parity_i, stop2_i) latched on start detection. Changes mid-frame have no effect until the next frame.
- Bit timing: OVERSAMPLE ticks per bit. Bit value is the majority of 3 samples at ticks OS/2-1, OS/2 and OS/2+1 within the bit.
- FSM: IDLE -> START on start edge.
- START: majority 1 -> IDLE (false start, no push, no flag). Majority 0 -> DATA at end of bit.
- DATA: LSB first, N bits per data_bits_i -> PARITY if enabled, else STOP.
- PARITY: perr = received bit != expected. Even: XOR of data bits. Odd: inverted XOR.
- STOP: stop bit majority 0 -> ferr=1. With stop2_i=1, a second stop bit is checked; ferr = OR of both.
- Push: {ferr, perr, data} is pushed on the clock after the final stop-bit vote, and the FSM returns to IDLE immediately (mid-stop) for resync.
- A frame with perr or ferr is still pushed; the flags travel with the data.
- Break (all-zero data, ferr=1) is delivered as data 0x00 with ferr=1. A new start is only detected after the line returns high.
- FIFO: first-word fall-through. rx_data_o/flags show the head when rx_valid_o=1. Pop on rx_valid_o & rx_ready_i.
- Push while full and no pop: frame dropped, overrun_o=1 for one cycle, FIFO contents unchanged.
- Simultaneous push and pop when full: both occur, level unchanged, no overrun.
- Simultaneous push and pop when empty: the pushed word appears with rx_valid_o=1 next cycle; the pop is ignored.
- Pointers wrap modulo FIFO_DEPTH. level_o ranges 0..FIFO_DEPTH.
- Latency: rx_valid_o rises 1 cycle after push.

Test Plan:
- div_i=4, 8N1, send 0x55 (80 clk/bit), rx_ready_i=1 -> one word 0x55, perr=0, ferr=0. rx_valid_o rises ~9.5 bit times after the start edge.
- Even parity, 8 bits, send 0xA3 with parity bit 0 -> perr=0. Repeat with parity bit 1 -> perr=1, data 0xA3. Odd mode, parity bit 1 -> perr=0.
- 5 data bits, 2 stop bits, send 0x13 with the second stop bit 0 -> data 0x13, ferr=1. Upper 3 bits of rx_data_o are 0.
- Glitch: 2-tick low pulse on an idle line -> no push, busy_o returns 0 within 1 bit time, level_o stays 0.
- rx_ready_i=0, send 9 frames 0x01..0x09 -> level_o=8, overrun_o pulses once. Then rx_ready_i=1 -> pops 0x01..0x08 in order.
- Assert rst_i during the DATA state of frame 0x3C, release, send 0x5A -> only 0x5A delivered; all outputs 0 during reset.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with a first-word fall-through
// output FIFO.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   uart_rx_i    asynchronous serial input, idle high
//   div_i        oversample tick period minus 1, in clk_i cycles
//   data_bits_i  0:5, 1:6, 2:7, 3:8 data bits
//   parity_i     0/3:none, 1:even, 2:odd
//   stop2_i      1 = check a second stop bit
//   rx_data_o    FIFO head data, right-justified (0 when empty)
//   rx_perr_o    FIFO head parity error flag
//   rx_ferr_o    FIFO head framing error flag
//   rx_valid_o   FIFO not empty
//   rx_ready_i   consumer accepts head
//   level_o      FIFO occupancy
//   overrun_o    one-cycle pulse when a completed frame is dropped
//   busy_o       receiver not idle
module uart_rx_fifo #(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          uart_rx_i,
  input  logic [DIV_W-1:0]              div_i,
  input  logic [1:0]                    data_bits_i,
  input  logic [1:0]                    parity_i,
  input  logic                          stop2_i,
  output logic [7:0]                    rx_data_o,
  output logic                          rx_perr_o,
  output logic                          rx_ferr_o,
  output logic                          rx_valid_o,
  input  logic                          rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overrun_o,
  output logic                          busy_o
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_V0   = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_V1   = OSW'(OVERSAMPLE / 2);
  localparam logic [OSW-1:0] OS_V2   = OSW'(OVERSAMPLE / 2 + 1);
  localparam logic [AW:0]    DEPTH   = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Expected parity bit: even = XOR of data, odd = its inverse.
  function automatic logic par_expect(input logic [7:0] d, input logic [1:0] mode);
    return (mode == 2'd2) ? ~(^d) : (^d);
  endfunction

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q, hist_q;
  logic [DIV_W-1:0]  tcnt_q, div_q;
  logic [OSW-1:0]    os_q;
  logic [2:0]        last_idx_q, bit_cnt_q;
  logic [1:0]        par_q;
  logic              stop2_q, stop_second_q;
  logic              v0_q, v1_q;
  logic [7:0]        data_q;
  logic              perr_q, ferr_q;
  logic              push_q, overrun_q;
  logic [9:0]        mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;

  logic start_edge, tick, vote, bit_end, maj, par_en, frame_done;
  logic push, pop, full, wr_en;
  logic [9:0] head;

  assign start_edge = ~sync2_q & hist_q;
  assign tick       = (state_q != IDLE) && (tcnt_q == div_q);
  assign vote       = tick && (os_q == OS_V2);
  assign bit_end    = tick && (os_q == OS_LAST);
  assign maj        = maj3(v0_q, v1_q, sync2_q);
  assign par_en     = (par_q == 2'd1) || (par_q == 2'd2);

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (start_edge) state_d = START;
      START:  if (vote && maj) state_d = IDLE;      // false start
              else if (bit_end) state_d = DATA;
      DATA:   if (bit_end && (bit_cnt_q == last_idx_q))
                state_d = par_en ? PARITY : STOP;
      PARITY: if (bit_end) state_d = STOP;
      // Leave mid-stop-bit on the final vote so the next start edge is caught.
      STOP:   if (vote && (!stop2_q || stop_second_q)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy_o     = (state_q != IDLE);
    frame_done = (state_q == STOP) && vote && (!stop2_q || stop_second_q);
  end

  // Stage: synchroniser, bit timing, frame control
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      hist_q        <= 1'b1;
      tcnt_q        <= '0;
      os_q          <= '0;
      div_q         <= '0;
      last_idx_q    <= 3'd7;
      par_q         <= 2'd0;
      stop2_q       <= 1'b0;
      stop_second_q <= 1'b0;
      bit_cnt_q     <= '0;
      push_q        <= 1'b0;
    end else begin
      sync1_q <= uart_rx_i;
      sync2_q <= sync1_q;
      hist_q  <= sync2_q;
      push_q  <= frame_done;
      if (state_q == IDLE) begin
        tcnt_q        <= '0;
        os_q          <= '0;
        bit_cnt_q     <= '0;
        stop_second_q <= 1'b0;
        if (start_edge) begin
          div_q      <= div_i;
          last_idx_q <= 3'd4 + {1'b0, data_bits_i};
          par_q      <= parity_i;
          stop2_q    <= stop2_i;
        end
      end else begin
        tcnt_q <= tick ? '0 : tcnt_q + 1'b1;
        if (tick) os_q <= (os_q == OS_LAST) ? '0 : os_q + 1'b1;
        if ((state_q == DATA) && bit_end) bit_cnt_q <= bit_cnt_q + 3'd1;
        if ((state_q == STOP) && bit_end) stop_second_q <= 1'b1;
      end
    end
  end

  // Stage: sample votes and frame assembly
  always_ff @(posedge clk_i) begin
    if (tick && (os_q == OS_V0)) v0_q <= sync2_q;
    if (tick && (os_q == OS_V1)) v1_q <= sync2_q;
    if (state_q == IDLE) begin
      data_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else if (vote) begin
      unique case (state_q)
        DATA:    data_q[bit_cnt_q] <= maj;
        PARITY:  perr_q <= (maj != par_expect(data_q, par_q));
        STOP:    ferr_q <= ferr_q | ~maj;
        default: ;
      endcase
    end
  end

  // Stage: output FIFO
  assign push  = push_q;
  assign pop   = rx_valid_o & rx_ready_i;
  assign full  = (count_q == DEPTH);
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= {ferr_q, perr_q, data_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push && full && !pop;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign rx_valid_o = (count_q != '0);
  assign rx_data_o  = rx_valid_o ? head[7:0] : 8'h00;
  assign rx_perr_o  = rx_valid_o & head[8];
  assign rx_ferr_o  = rx_valid_o & head[9];
  assign level_o    = count_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with div_i=4, OVERSAMPLE=16 (80 clk/bit).
module tb_uart_rx_fifo;

  localparam int BIT = 80;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        uart_rx_i;
  logic [15:0] div_i;
  logic [1:0]  data_bits_i;
  logic [1:0]  parity_i;
  logic        stop2_i;
  logic [7:0]  rx_data_o;
  logic        rx_perr_o, rx_ferr_o, rx_valid_o;
  logic        rx_ready_i;
  logic [3:0]  level_o;
  logic        overrun_o, busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovr_cnt = 0;
  logic [9:0] popq [$];
  int         popt [$];

  uart_rx_fifo #(.OVERSAMPLE(16), .DIV_W(16), .FIFO_DEPTH(8)) dut (
    .clk_i(clk), .rst_i(rst_i), .uart_rx_i(uart_rx_i), .div_i(div_i),
    .data_bits_i(data_bits_i), .parity_i(parity_i), .stop2_i(stop2_i),
    .rx_data_o(rx_data_o), .rx_perr_o(rx_perr_o), .rx_ferr_o(rx_ferr_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .level_o(level_o),
    .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted word ({ferr, perr, data}) and every overrun pulse.
  always @(negedge clk) begin
    if (!rst_i && rx_valid_o && rx_ready_i) begin
      popq.push_back({rx_ferr_o, rx_perr_o, rx_data_o});
      popt.push_back(cyc);
    end
    if (overrun_o) ovr_cnt <= ovr_cnt + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input string tag, input logic [9:0] exp);
    logic [9:0] w;
    chk({tag, "_present"}, 32'(popq.size() != 0), 32'd1);
    if (popq.size() != 0) begin
      w = popq.pop_front();
      void'(popt.pop_front());
      chk(tag, 32'(w), 32'(exp));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bits are sent LSB first, starting with the start bit in bits[0].
  task automatic send_frame(input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      uart_rx_i = bits[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    uart_rx_i = 1'b1;
  endtask

  initial begin
    int t0;
    int lat;
    int ovr0;
    logic [7:0] b8;

    rst_i       = 1'b1;
    uart_rx_i   = 1'b1;
    div_i       = 16'd4;
    data_bits_i = 2'd3;
    parity_i    = 2'd0;
    stop2_i     = 1'b0;
    rx_ready_i  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(rx_valid_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_data", 32'(rx_data_o), 32'd0);
    chk("rst_overrun", 32'(overrun_o), 32'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    idle(10);

    // 8N1 0x55 with consumer always ready
    rx_ready_i = 1'b1;
    t0 = cyc;
    send_frame({2'b00, 1'b1, 8'h55, 1'b0}, 10);
    idle(40);
    chk("f55_count", 32'(popq.size()), 32'd1);
    if (popt.size() != 0) lat = popt[0] - t0;
    else lat = -1;
    chk("f55_latency_window", 32'(lat >= 740 && lat <= 800), 32'd1);
    expect_word("f55_word", 10'h055);

    // Even parity, correct parity bit 0
    parity_i = 2'd1;
    send_frame({1'b0, 1'b1, 1'b0, 8'hA3, 1'b0}, 11);
    idle(40);
    expect_word("even_ok", 10'h0A3);
    // Even parity, wrong parity bit
    send_frame({1'b0, 1'b1, 1'b1, 8'hA3, 1'b0}, 11);
    idle(40);
    expect_word("even_perr", 10'h1A3);
    // Odd parity, correct parity bit 1
    parity_i = 2'd2;
    send_frame({1'b0, 1'b1, 1'b1, 8'hA3, 1'b0}, 11);
    idle(40);
    expect_word("odd_ok", 10'h0A3);

    // 5 data bits, 2 stop bits, second stop bit low
    parity_i    = 2'd0;
    data_bits_i = 2'd0;
    stop2_i     = 1'b1;
    send_frame({4'b0000, 1'b0, 1'b1, 5'h13, 1'b0}, 8);
    idle(40);
    expect_word("5b_ferr", 10'h213);
    data_bits_i = 2'd3;
    stop2_i     = 1'b0;

    // Glitch: 2-tick low pulse
    uart_rx_i = 1'b0;
    idle(10);
    uart_rx_i = 1'b1;
    @(negedge clk);
    chk("glitch_busy_on", 32'(busy_o), 32'd1);
    idle(70);
    @(negedge clk);
    chk("glitch_busy_off", 32'(busy_o), 32'd0);
    idle(900);
    chk("glitch_level", 32'(level_o), 32'd0);
    chk("glitch_nopush", 32'(popq.size()), 32'd0);

    // Overrun: nine frames into an 8-deep FIFO with no consumer
    rx_ready_i = 1'b0;
    ovr0 = ovr_cnt;
    for (int i = 1; i <= 9; i++) begin
      b8 = 8'(i);
      send_frame({2'b00, 1'b1, b8, 1'b0}, 10);
      idle(10);
    end
    idle(40);
    @(negedge clk);
    chk("ovr_level", 32'(level_o), 32'd8);
    chk("ovr_valid", 32'(rx_valid_o), 32'd1);
    chk("ovr_head", 32'(rx_data_o), 32'h01);
    chk("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
    @(posedge clk);
    #1 rx_ready_i = 1'b1;
    idle(20);
    rx_ready_i = 1'b0;
    chk("ovr_drain_count", 32'(popq.size()), 32'd8);
    for (int k = 1; k <= 8; k++) begin
      b8 = 8'(k);
      expect_word("ovr_drain", {2'b00, b8});
    end
    @(negedge clk);
    chk("ovr_empty", 32'(level_o), 32'd0);

    // Reset during DATA of 0x3C, with a word sitting in the FIFO
    send_frame({2'b00, 1'b1, 8'h77, 1'b0}, 10);
    idle(40);
    chk("pre_rst_level", 32'(level_o), 32'd1);
    uart_rx_i = 1'b0;            // start, bit0=0, bit1=0 of 0x3C
    idle(3 * BIT);
    uart_rx_i = 1'b1;            // bit2=1; frame is then abandoned
    idle(40);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy_o), 32'd1);
    @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", 32'(rx_valid_o), 32'd0);
    chk("midrst_level", 32'(level_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_data", 32'(rx_data_o), 32'd0);
    chk("midrst_flags", 32'({rx_ferr_o, rx_perr_o, overrun_o}), 32'd0);
    @(posedge clk);
    #1 rst_i = 1'b0;
    idle(200);
    chk("postrst_busy", 32'(busy_o), 32'd0);
    chk("postrst_level", 32'(level_o), 32'd0);
    rx_ready_i = 1'b1;
    send_frame({2'b00, 1'b1, 8'h5A, 1'b0}, 10);
    idle(40);
    chk("postrst_count", 32'(popq.size()), 32'd1);
    expect_word("postrst_word", 10'h05A);
    chk("total_overruns", 32'(ovr_cnt - ovr0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
